// File: rtl/ffn_argmax_classifier.sv
// Fully-connected output stage: saturating parallel dot products over a beat stream,
// followed by a one-class-per-cycle argmax scan that reports the winning class and score.
module ffn_argmax_classifier #(
  parameter  int unsigned IN_W        = 8,
  parameter  int unsigned W_W         = 8,
  parameter  int unsigned ACC_W       = 24,
  parameter  int unsigned NUM_CLASSES = 10,
  localparam int unsigned IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_W-1:0]              in_feature,
  input  logic [NUM_CLASSES*W_W-1:0]   in_weights,
  input  logic                         in_last,
  output logic                         done,
  output logic [IDX_W-1:0]             class_idx,
  output logic [ACC_W-1:0]             class_score,
  output logic [NUM_CLASSES*ACC_W-1:0] scores,
  output logic                         sat
);

  localparam int unsigned PROD_W = IN_W + W_W;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {ST_ACCUM = 1'b0, ST_SCAN = 1'b1} state_e;

  state_e                 state_q;
  logic                   in_ready_q;
  logic                   done_q;
  logic                   sat_q;
  logic                   sat_pend_q;
  logic                   sat_cap_q;
  logic [ACC_W-1:0]       acc_q    [NUM_CLASSES];
  logic [ACC_W-1:0]       acc_d    [NUM_CLASSES];
  logic [ACC_W-1:0]       scores_q [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] ovf;
  logic [IDX_W-1:0]       scan_idx_q;
  logic [IDX_W-1:0]       best_idx_q;
  logic [IDX_W-1:0]       best_idx_d;
  logic [IDX_W-1:0]       class_idx_q;
  logic [ACC_W-1:0]       best_q;
  logic [ACC_W-1:0]       best_d;
  logic [ACC_W-1:0]       class_score_q;
  logic [ACC_W-1:0]       cur_score;
  logic                   take;
  logic                   scan_last;

  // Per-class multiply and saturating accumulate; overflow is a sign mismatch of the extra bit.
  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_class
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W:0]    sum;

    assign prod     = PROD_W'($signed(in_feature)) * PROD_W'($signed(in_weights[c*W_W +: W_W]));
    assign sum      = $signed({acc_q[c][ACC_W-1], acc_q[c]}) + (ACC_W+1)'(prod);
    assign ovf[c]   = sum[ACC_W] ^ sum[ACC_W-1];
    assign acc_d[c] = !ovf[c] ? sum[ACC_W-1:0] : (sum[ACC_W] ? ACC_MIN : ACC_MAX);
    assign scores[c*ACC_W +: ACC_W] = scores_q[c];
  end

  // Scan compare: index 0 seeds the running best, later ones win only when strictly greater.
  assign cur_score  = scores_q[scan_idx_q];
  assign take       = (scan_idx_q == '0) || ($signed(cur_score) > $signed(best_q));
  assign best_d     = take ? cur_score : best_q;
  assign best_idx_d = take ? scan_idx_q : best_idx_q;
  assign scan_last  = (scan_idx_q == IDX_W'(NUM_CLASSES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_ACCUM;
      in_ready_q    <= 1'b1;
      done_q        <= 1'b0;
      sat_q         <= 1'b0;
      sat_pend_q    <= 1'b0;
      sat_cap_q     <= 1'b0;
      scan_idx_q    <= '0;
      best_idx_q    <= '0;
      best_q        <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        acc_q[c]    <= '0;
        scores_q[c] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        // Abort drops the vector in flight but leaves reported results untouched.
        state_q    <= ST_ACCUM;
        in_ready_q <= 1'b1;
        sat_pend_q <= 1'b0;
        scan_idx_q <= '0;
        for (int c = 0; c < NUM_CLASSES; c++) acc_q[c] <= '0;
      end else begin
        case (state_q)
          ST_ACCUM: begin
            if (in_valid) begin
              if (in_last) begin
                for (int c = 0; c < NUM_CLASSES; c++) begin
                  scores_q[c] <= acc_d[c];
                  acc_q[c]    <= '0;
                end
                sat_cap_q  <= sat_pend_q | (|ovf);
                sat_pend_q <= 1'b0;
                scan_idx_q <= '0;
                state_q    <= ST_SCAN;
                in_ready_q <= 1'b0;
              end else begin
                for (int c = 0; c < NUM_CLASSES; c++) acc_q[c] <= acc_d[c];
                sat_pend_q <= sat_pend_q | (|ovf);
              end
            end
          end
          ST_SCAN: begin
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            scan_idx_q <= scan_idx_q + IDX_W'(1);
            if (scan_last) begin
              class_idx_q   <= best_idx_d;
              class_score_q <= best_d;
              sat_q         <= sat_cap_q;
              done_q        <= 1'b1;
              state_q       <= ST_ACCUM;
              in_ready_q    <= 1'b1;
            end
          end
          default: begin
            state_q    <= ST_ACCUM;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign done        = done_q;
  assign class_idx   = class_idx_q;
  assign class_score = class_score_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_ffn_argmax_classifier.sv
// Scoreboard bench for ffn_argmax_classifier: an integer reference model predicts each
// vector's result and output timing; a separate monitor compares whenever done pulses.
module tb_ffn_argmax_classifier;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned W_W   = 8;
  localparam int unsigned ACC_W = 16;
  localparam int unsigned NC    = 10;
  localparam int unsigned IDX_W = $clog2(NC);
  localparam int          A_MAX = (1 << (ACC_W - 1)) - 1;
  localparam int          A_MIN = -(1 << (ACC_W - 1));

  typedef struct packed {
    logic [NC*ACC_W-1:0] scores;
    logic [IDX_W-1:0]    idx;
    logic [ACC_W-1:0]    score;
    logic                sat;
  } res_t;

  logic                clock = 1'b0;
  logic                reset;
  logic                clear;
  logic                in_valid;
  logic                in_ready;
  logic [IN_W-1:0]     in_feature;
  logic [NC*W_W-1:0]   in_weights;
  logic                in_last;
  logic                done;
  logic [IDX_W-1:0]    class_idx;
  logic [ACC_W-1:0]    class_score;
  logic [NC*ACC_W-1:0] scores;
  logic                sat;

  int errors = 0;
  int checks = 0;

  ffn_argmax_classifier #(
    .IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W), .NUM_CLASSES(NC)
  ) dut (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_feature(in_feature), .in_weights(in_weights), .in_last(in_last), .done(done),
    .class_idx(class_idx), .class_score(class_score), .scores(scores), .sat(sat)
  );

  always #5 clock = ~clock;

  // Reference model state and scoreboard queue.
  int                  m_acc [NC];
  bit                  m_pend   = 1'b0;
  bit                  m_scan   = 1'b0;
  int                  m_cnt    = 0;
  logic [NC*ACC_W-1:0] m_scores = '0;
  bit                  exp_done = 1'b0;
  bit                  exp_ready = 1'b1;
  res_t                exp_q[$];
  logic [IDX_W-1:0]    h_idx    = '0;
  logic [ACC_W-1:0]    h_score  = '0;
  logic                h_sat    = 1'b0;
  int                  wv [NC];

  task automatic chk(input string name, input logic [NC*ACC_W-1:0] got, input logic [NC*ACC_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic flush_model();
    for (int c = 0; c < NC; c++) m_acc[c] = 0;
    m_pend = 0; m_scan = 0; m_cnt = 0; m_scores = '0;
    exp_done = 0; exp_ready = 1;
    exp_q.delete();
    h_idx = '0; h_score = '0; h_sat = 1'b0;
  endtask

  always @(posedge reset) flush_model();

  // Model: decides at each falling edge what the next rising edge does.
  always @(negedge clock) begin
    int   f, w, s, best;
    int   sc [NC];
    res_t r;
    if (reset) begin
      exp_done  = 0;
      exp_ready = 1;
    end else begin
      exp_done = 0;
      if (clear) begin
        for (int c = 0; c < NC; c++) m_acc[c] = 0;
        m_pend = 0;
        if (m_scan) begin
          m_scan = 0;
          if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
      end else if (m_scan) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_scan   = 0;
          exp_done = 1;
        end
      end else if (in_valid) begin
        f = $signed(in_feature);
        for (int c = 0; c < NC; c++) begin
          w = $signed(in_weights[c*W_W +: W_W]);
          s = m_acc[c] + f * w;
          if (s > A_MAX) begin s = A_MAX; m_pend = 1; end
          if (s < A_MIN) begin s = A_MIN; m_pend = 1; end
          m_acc[c] = s;
        end
        if (in_last) begin
          best = 0;
          for (int c = 0; c < NC; c++) begin
            sc[c] = m_acc[c];
            if (sc[c] > sc[best]) best = c;
            r.scores[c*ACC_W +: ACC_W] = ACC_W'(sc[c]);
          end
          r.idx   = IDX_W'(best);
          r.score = ACC_W'(sc[best]);
          r.sat   = m_pend;
          exp_q.push_back(r);
          m_scores = r.scores;
          for (int c = 0; c < NC; c++) m_acc[c] = 0;
          m_pend = 0;
          m_scan = 1;
          m_cnt  = NC;
        end
      end
      exp_ready = !m_scan;
    end
  end

  // Monitor: samples shortly after each rising edge, pops on done.
  always @(posedge clock) begin
    res_t r;
    #2;
    chk("in_ready", NC*ACC_W'(in_ready), NC*ACC_W'(exp_ready));
    if (done) begin
      if (!exp_done || exp_q.size() == 0) begin
        chk("done_unexpected", NC*ACC_W'(done), '0);
      end else begin
        r = exp_q.pop_front();
        chk("class_idx", NC*ACC_W'(class_idx), NC*ACC_W'(r.idx));
        chk("class_score", NC*ACC_W'(class_score), NC*ACC_W'(r.score));
        chk("sat", NC*ACC_W'(sat), NC*ACC_W'(r.sat));
        chk("scores_at_done", scores, r.scores);
        h_idx = r.idx; h_score = r.score; h_sat = r.sat;
      end
    end else begin
      if (exp_done) begin
        chk("done_missing", NC*ACC_W'(done), NC*ACC_W'(1));
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      chk("hold_idx", NC*ACC_W'(class_idx), NC*ACC_W'(h_idx));
      chk("hold_score", NC*ACC_W'(class_score), NC*ACC_W'(h_score));
      chk("hold_sat", NC*ACC_W'(sat), NC*ACC_W'(h_sat));
    end
    chk("scores", scores, m_scores);
  end

  function automatic logic [NC*W_W-1:0] pack_w();
    logic [NC*W_W-1:0] v;
    for (int c = 0; c < NC; c++) v[c*W_W +: W_W] = W_W'(wv[c]);
    return v;
  endfunction

  // Present one beat and hold it until the block accepts it.
  task automatic beat(input int f, input bit last);
    bit acc;
    bit ok;
    in_feature = IN_W'(f);
    in_weights = pack_w();
    in_last    = last;
    in_valid   = 1'b1;
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clock);
      acc = in_ready && !clear && !reset;
      @(posedge clock);
      #1;
      ok = acc;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL beat_accept_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_clear();
    clear      = 1'b1;
    in_valid   = 1'b1;
    in_feature = IN_W'(7);
    in_last    = 1'b1;
    @(posedge clock); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic set_lin();
    for (int c = 0; c < NC; c++) wv[c] = c;
  endtask

  task automatic set_rand();
    for (int c = 0; c < NC; c++) wv[c] = int'($urandom_range(0, 255)) - 128;
  endtask

  initial begin
    int len, wait_cyc;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_feature = '0; in_weights = '0;
    for (int c = 0; c < NC; c++) m_acc[c] = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    idle(2);

    // Linear weights, three beats of 2: scores 6c, class 9 wins with 54.
    set_lin(); beat(2, 0); beat(2, 0); beat(2, 1); idle(14);

    // Tie at 100 between classes 3 and 7: lowest index wins.
    set_lin(); wv[3] = 10; wv[7] = 10; beat(10, 1); idle(12);

    // Saturation of class 0, then a clean vector reports sat=0.
    for (int c = 0; c < NC; c++) wv[c] = 0;
    wv[0] = 127; beat(127, 0); beat(127, 0); beat(127, 1); idle(12);
    set_lin(); beat(2, 0); beat(2, 0); beat(2, 1); idle(12);

    // All negative: class 5 at -4, others -10.
    for (int c = 0; c < NC; c++) wv[c] = -5;
    wv[5] = -2; beat(2, 1); idle(12);

    // Abort after two beats, then a fresh single-beat vector.
    set_lin(); beat(3, 0); beat(3, 0); idle(2); do_clear(); idle(1);
    beat(1, 1); idle(12);

    // Next vector held on the bus throughout the scan.
    set_rand(); beat(int'($urandom_range(0, 255)) - 128, 0); beat(int'($urandom_range(0, 255)) - 128, 1);
    set_rand(); beat(int'($urandom_range(0, 255)) - 128, 0); beat(int'($urandom_range(0, 255)) - 128, 1);
    idle(12);

    // Reset in the middle of a scan.
    set_lin(); beat(5, 1); idle(5);
    reset = 1'b1; idle(2); reset = 1'b0; idle(3);

    // Random vectors with random gaps and occasional aborts.
    for (int v = 0; v < 40; v++) begin
      len = int'($urandom_range(1, 6));
      for (int b = 0; b < len; b++) begin
        set_rand();
        if (b == len - 1 || $urandom_range(0, 9) != 0) begin
          beat(int'($urandom_range(0, 255)) - 128, b == len - 1);
          if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 3)));
        end else begin
          do_clear();
        end
      end
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 12)));
    end

    in_valid = 1'b0;
    wait_cyc = 0;
    while ((exp_q.size() != 0 || m_scan) && wait_cyc < 200) begin
      @(posedge clock); #1;
      wait_cyc++;
    end
    if (exp_q.size() != 0 || m_scan) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
    end
    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
